i2c_slave_write_byte: RTL

//   Slave-side byte transmitter for I2C read transfers: shifts one byte out on SDA, MSB first.

---
 rtl/i2c_slave_write_byte.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_write_byte.sv
// I2C slave byte transmitter: shifts DATA_WIDTH bits MSB first on SDA, then samples the master's ACK on the 9th SCL.
// SDA changes HOLD_CYCLES clocks after each SCL fall; the SCL master paces everything, so there is no backpressure beyond SCL itself.
module i2c_slave_write_byte #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  busy,
  output logic                  ack,
  output logic                  error,
  output logic                  finish
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_DRIVE,
    S_HIGH,
    S_ACK_HOLD,
    S_ACK_WAIT,
    S_ACK_HIGH
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]            hold_q, hold_d;
  logic                  scl_last_q;
  logic                  sda_q, sda_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  rise, fall, hold_done;

  assign rise      = !scl_last_q && scl;
  assign fall      = scl_last_q && !scl;
  // Counter is loaded on the fall cycle, so reaching 1 means HOLD_CYCLES clocks have elapsed.
  assign hold_done = (hold_q <= 8'd1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    sda_d     = sda_q;
    ack_d     = ack_q;
    err_d     = err_q;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !scl) begin
          shift_d   = data_in;
          bit_cnt_d = CW'(DATA_WIDTH - 1);
          err_d     = 1'b0;
          ack_d     = 1'b0;
          hold_d    = 8'(HOLD_CYCLES);
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rise) begin
          err_d   = 1'b1;
          state_d = S_HIGH;
        end else if (hold_done) begin
          sda_d   = shift_q[DATA_WIDTH-1];
          state_d = S_DRIVE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_DRIVE: begin
        if (rise) state_d = S_HIGH;
      end
      S_HIGH: begin
        // Line readback differs from what we drive: lost arbitration or a stuck line.
        if (scl && (sda_in != sda_q)) err_d = 1'b1;
        if (fall) begin
          hold_d = 8'(HOLD_CYCLES);
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - CW'(1);
            state_d   = S_HOLD;
          end else begin
            state_d = S_ACK_HOLD;
          end
        end
      end
      S_ACK_HOLD: begin
        if (rise) begin
          err_d   = 1'b1;
          sda_d   = 1'b1;
          state_d = S_ACK_HIGH;
        end else if (hold_done) begin
          sda_d   = 1'b1;
          state_d = S_ACK_WAIT;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_ACK_WAIT: begin
        if (rise) begin
          ack_d   = !sda_in;
          state_d = S_ACK_HIGH;
        end
      end
      S_ACK_HIGH: begin
        if (fall) begin
          finish  = 1'b1;
          sda_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        sda_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      scl_last_q <= 1'b1;
      sda_q      <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      scl_last_q <= scl;
      sda_q      <= sda_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_out = sda_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign error   = err_q;

endmodule
